// File: rtl/audio_uart_pkg.sv
// Shared definitions for the audio-to-UART framing path.
// Contents:
//   DEFAULT_SYNC_BYTE - first byte of every frame unless overridden
//   framer_state_e    - framer FSM states
//   frame_len()       - bytes per frame for a given sample width
package audio_uart_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO
  } framer_state_e;

  // One sync byte, the sample bytes, then one checksum byte.
  function automatic int frame_len(input int sample_w);
    return sample_w / 8 + 2;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples in front of the framer.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   push, din   - write request and data (ignored when full unless popping)
//   pop, dout   - read request (ignored when empty); dout is registered and
//                 valid on the cycle after pop
//   level       - current occupancy, 0..DEPTH
//   full, empty - occupancy flags derived from level
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = dout_q;

  // A push into a full FIFO is only legal when the same cycle pops, because
  // the read frees the slot the write lands in.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_sample_framer.sv
// Buffers audio samples and serialises each one into a byte frame
// (SYNC, sample bytes MSB-first, XOR of the sample bytes) for uart_transmit.
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   in_sample/in_valid/in_ready - sample input handshake
//   tx_data/tx_send/tx_busy     - byte handshake with uart_transmit
//   frame_active          - a frame is being transmitted
//   fifo_level            - sample FIFO occupancy
//   overflow, ack_err     - sticky error flags, cleared only by reset
module uart_sample_framer
  import audio_uart_pkg::*;
#(
  parameter int         SAMPLE_W    = 16,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic                          frame_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          ack_err
);

  localparam int N     = frame_len(SAMPLE_W);
  localparam int IDX_W = $clog2(N + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  framer_state_e         state_q, state_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  frame_active_q, frame_active_d;
  logic                  overflow_q, overflow_d;
  logic                  ack_err_q, ack_err_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]   fifo_dout;
  logic                  last_byte, timed_out;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_sample),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // in_ready follows the registered level only; a push while full is still
  // taken when the framer pops in the same cycle.
  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !tx_busy;
  assign fifo_push = in_valid && (in_ready || fifo_pop);
  assign last_byte = (byte_idx_q == IDX_W'(N - 1));
  assign timed_out = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      chk_q          <= '0;
      tx_data_q      <= '0;
      byte_idx_q     <= '0;
      to_cnt_q       <= '0;
      frame_active_q <= 1'b0;
      overflow_q     <= 1'b0;
      ack_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      chk_q          <= chk_d;
      tx_data_q      <= tx_data_d;
      byte_idx_q     <= byte_idx_d;
      to_cnt_q       <= to_cnt_d;
      frame_active_q <= frame_active_d;
      overflow_q     <= overflow_d;
      ack_err_q      <= ack_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_pop) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: if (tx_busy || timed_out) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = last_byte ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag updates. The popped sample only appears on fifo_dout
  // in the first LOAD, so it is captured there while SYNC goes out.
  always_comb begin
    shift_d        = shift_q;
    chk_d          = chk_q;
    tx_data_d      = tx_data_q;
    byte_idx_d     = byte_idx_q;
    to_cnt_d       = to_cnt_q;
    frame_active_d = frame_active_q;
    ack_err_d      = ack_err_q;
    overflow_d     = overflow_q | (in_valid && !in_ready && !fifo_pop);
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          chk_d      = '0;
          byte_idx_d = '0;
        end
      end
      LOAD: begin
        frame_active_d = 1'b1;
        if (byte_idx_q == '0) begin
          tx_data_d = SYNC_BYTE;
          shift_d   = fifo_dout;
        end else if (last_byte) begin
          tx_data_d = chk_q;
        end else begin
          tx_data_d = shift_q[SAMPLE_W-1 -: 8];
          chk_d     = chk_q ^ shift_q[SAMPLE_W-1 -: 8];
          shift_d   = shift_q << 8;
        end
      end
      SEND: to_cnt_d = '0;
      WAIT_HI: begin
        if (!tx_busy) begin
          if (timed_out) ack_err_d = 1'b1;
          else           to_cnt_d  = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_byte) frame_active_d = 1'b0;
          else           byte_idx_d     = byte_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // tx_send decodes straight from the state so reset drops it immediately.
  always_comb begin
    tx_send      = (state_q == SEND);
    tx_data      = tx_data_q;
    frame_active = frame_active_q;
    overflow     = overflow_q;
    ack_err      = ack_err_q;
  end

endmodule
